// File: rtl/mod_shift_reduce_pkg.sv
// Shared types and constants for the shift-and-reduce modular unit.
package mod_shift_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic ERR_NONE     = 1'b0;
  localparam logic ERR_BAD_ARGS = 1'b1;

endpackage

// File: rtl/mod_shift_reduce_sub_step.sv
// One restoring-division step: conditional subtract of the modulus from r'.
module mod_sub_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   r_shift,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  // The true difference is always below modulus, so modulo-2^WIDTH arithmetic is exact.
  always_comb begin
    q_bit  = (r_shift >= {1'b0, modulus});
    r_next = q_bit ? (r_shift[WIDTH-1:0] - modulus) : r_shift[WIDTH-1:0];
  end

endmodule

// File: rtl/mod_shift_reduce.sv
// Computes (num_in << len) mod modulus, one dividend bit per cycle.
// Optional quotient output enabled by defining MOD_SHIFT_REDUCE_QUOT_EN.
//
// state | meaning
// IDLE  | waiting for start; result/err hold last completion
// CALC  | shifting dividend bits through the reduce step
// DONE  | one-cycle completion pulse
module mod_shift_reduce
  import mod_shift_reduce_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [WIDTH-1:0] num_in,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
`ifdef MOD_SHIFT_REDUCE_QUOT_EN
  ,
  output logic [2*WIDTH-1:0] quotient
`endif
);

  localparam int CNT_W = $clog2(2*WIDTH+1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] mod_q;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r_next;
  logic             q_bit;
  logic             args_bad;

  assign args_bad = (modulus == '0) || (32'(len) > 32'(WIDTH));
  assign busy     = (state != IDLE);

  // num_in is shifted out MSB first, then zeros fill the len low-order dividend bits.
  mod_sub_step #(.WIDTH(WIDTH)) u_step (
    .r_shift ({r, dvd[WIDTH-1]}),
    .modulus (mod_q),
    .r_next  (r_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      cnt    <= '0;
      dvd    <= '0;
      mod_q  <= '0;
      r      <= '0;
      result <= '0;
      err    <= ERR_NONE;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mod_q  <= modulus;
            dvd    <= num_in;
            r      <= '0;
            result <= '0;
            if (args_bad) begin
              err   <= ERR_BAD_ARGS;
              cnt   <= '0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              err   <= ERR_NONE;
              cnt   <= CNT_W'(WIDTH) + CNT_W'(len);
              state <= CALC;
            end
          end
        end
        CALC: begin
          r   <= r_next;
          dvd <= {dvd[WIDTH-2:0], 1'b0};
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            result <= r_next;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MOD_SHIFT_REDUCE_QUOT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      quotient <= '0;
    end else if (state == IDLE && start) begin
      quotient <= '0;
    end else if (state == CALC) begin
      quotient <= {quotient[2*WIDTH-2:0], q_bit};
    end
  end
`else
  logic unused_q_bit;
  assign unused_q_bit = q_bit;
`endif

endmodule

// File: tb/tb_mod_shift_reduce.sv
// Scoreboard bench for mod_shift_reduce; quotient checked when MOD_SHIFT_REDUCE_QUOT_EN is defined.
module tb_mod_shift_reduce;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic [31:0] num_in = '0;
  logic [31:0] modulus = '0;
  logic        busy, done, err;
  logic [31:0] result;
`ifdef MOD_SHIFT_REDUCE_QUOT_EN
  logic [63:0] quotient;
`endif

  mod_shift_reduce #(.WIDTH(32), .LEN_W(8)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .len     (len),
    .num_in  (num_in),
    .modulus (modulus),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .result  (result)
`ifdef MOD_SHIFT_REDUCE_QUOT_EN
    ,
    .quotient(quotient)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        err;
    logic [63:0] quot;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rstn && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 64'(result), 64'(e.res));
        check("err", 64'(err), 64'(e.err));
        check("latency", 64'(cyc - e.start_cyc + 1), 64'(e.lat));
        check("busy_at_done", 64'(busy), 64'd1);
`ifdef MOD_SHIFT_REDUCE_QUOT_EN
        check("quotient", quotient, e.quot);
`endif
      end
    end
  end

  // Drives one request at a negedge; an accepted start shows busy right after the edge.
  task automatic issue(input logic [31:0] n, input logic [7:0] l, input logic [31:0] m,
                       input logic [31:0] er, input logic ee, input logic [63:0] eq,
                       input bit push);
    exp_t e;
    @(negedge clk);
    num_in  = n;
    len     = l;
    modulus = m;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("accepted", 64'(busy), 64'd1);
    if (push) begin
      e.res       = er;
      e.err       = ee;
      e.quot      = eq;
      e.lat       = ee ? 1 : 32 + int'(l) + 1;
      e.start_cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL timeout: got no done within 300 cycles expected done");
    end
  endtask

  initial begin
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;

    issue(32'd5, 8'd8, 32'd7, 32'd6, 1'b0, 64'd182, 1'b1);
    wait_done();
    repeat (3) @(negedge clk);
    check("result_held", 64'(result), 64'd6);

    issue(32'd100, 8'd0, 32'd7, 32'd2, 1'b0, 64'd14, 1'b1);
    wait_done();
    issue(32'hFFFF_FFFF, 8'd32, 32'hFFFF_FFFB, 32'd20, 1'b0, 64'h1_0000_0004, 1'b1);
    wait_done();
    issue(32'h1234_5678, 8'd0, 32'd0, 32'd0, 1'b1, 64'd0, 1'b1);
    wait_done();
    issue(32'h1234_5678, 8'd33, 32'd7, 32'd0, 1'b1, 64'd0, 1'b1);
    wait_done();
    // back-to-back: next request issued in the idle cycle right after done
    issue(32'h1234_5678, 8'd4, 32'h0000_1000, 32'h780, 1'b0, 64'h12_3456, 1'b1);
    wait_done();
    issue(32'd9, 8'd0, 32'd10, 32'd9, 1'b0, 64'd0, 1'b1);
    wait_done();
    issue(32'd10, 8'd0, 32'd10, 32'd0, 1'b0, 64'd1, 1'b1);
    wait_done();
    issue(32'd1, 8'd32, 32'd3, 32'd1, 1'b0, 64'h5555_5555, 1'b1);
    wait_done();
    issue(32'hDEAD_BEEF, 8'd5, 32'd1, 32'd0, 1'b0, 64'h1B_D5B7_DDE0, 1'b1);
    wait_done();

    // start during CALC with different operands must be ignored
    issue(32'd5, 8'd8, 32'd7, 32'd6, 1'b0, 64'd182, 1'b1);
    repeat (5) @(negedge clk);
    num_in  = 32'd999;
    len     = 8'd3;
    modulus = 32'd11;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    num_in  = 32'd1;
    modulus = 32'd2;
    wait_done();
    repeat (50) @(negedge clk);

    // reset in CALC cycle 10 aborts the operation
    issue(32'd100, 8'd0, 32'd7, 32'd0, 1'b0, 64'd0, 1'b0);
    repeat (9) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_err", 64'(err), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (60) @(negedge clk);
    check("abort_idle", 64'(busy), 64'd0);
    issue(32'd100, 8'd0, 32'd7, 32'd2, 1'b0, 64'd14, 1'b1);
    wait_done();
    repeat (5) @(negedge clk);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_shift_reduce.md
MOD_SHIFT_REDUCE -- requirements
Module: mod_shift_reduce

Interface
- REQ-001 Parameters SHALL be:
  - WIDTH, 32, operand/modulus/result width in bits (>=8).
  - LEN_W, 8, width of the len port.
- REQ-002 Ports SHALL be:
  - clk  input  1  sole clock; all state changes on rising edge.
  - rstn  input  1  asynchronous, active-low reset.
  - start  input  1  operation request; sampled in IDLE only.
  - len  input  LEN_W  shift amount; result = (num_in * 2^len) mod modulus.
  - num_in  input  WIDTH  operand.
  - modulus  input  WIDTH  modulus.
  - busy  output  1  high whenever state != IDLE.
  - done  output  1  one-cycle completion pulse.
  - err  output  1  error status of the last operation; valid with done, held until next accepted start.
  - result  output  WIDTH  registered remainder; held until next accepted start.
- REQ-003 The block SHALL use one clock (clk) and an asynchronous active-low reset (rstn); no other clock or reset SHALL exist.

Function
- REQ-004 The FSM SHALL have states IDLE, CALC and DONE.
- REQ-005 In IDLE with start=1, the block SHALL capture len, num_in and modulus into internal registers, clear err and result, then move as follows:
  - If modulus==0 or len>WIDTH: go to DONE with err=1 and result=0 (error path).
  - Otherwise: go to CALC with iteration counter = WIDTH+len.
- REQ-006 The dividend SHALL be the 2*WIDTH-bit value {num_in, WIDTH'b0} >> (WIDTH-len), i.e. num_in<<len, zero-extended.
- REQ-007 Each CALC cycle SHALL process one dividend bit, MSB of the active WIDTH+len bits first:
  - r' = (r<<1)|bit, using a WIDTH+1-bit partial remainder r (initially 0).
  - If r' >= modulus, then r' = r' - modulus.
  - Decrement the counter.
- REQ-008 CALC SHALL last exactly WIDTH+len cycles; then the FSM goes to DONE and result loads r[WIDTH-1:0].
- REQ-009 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
- REQ-010 Latency: done SHALL be high in the (WIDTH+len+1)th cycle after the start-sampling edge. On the error path, done SHALL be high in the 1st cycle after that edge.
- REQ-011 start SHALL be ignored while busy=1; inputs changing during CALC SHALL NOT affect the result.
- REQ-012 result SHALL always satisfy result < modulus on a non-error completion, including len=0 and num_in >= modulus.
- REQ-013 A start asserted in the cycle IDLE is re-entered after DONE SHALL be accepted (back-to-back operations, one idle cycle minimum).

Reset
- REQ-014 On rstn=0, asynchronously: state=IDLE, busy=0, done=0, err=0, result=0, counter=0, r=0.
- REQ-015 Reset asserted mid-CALC SHALL abort the operation; no done pulse SHALL follow after release.

Configuration
- REQ-016 With macro MOD_SHIFT_REDUCE_QUOT_EN defined, the block SHALL add:
  - Output port quotient, 2*WIDTH bits, holding floor((num_in<<len)/modulus).
  - Quotient bits shifted in per CALC cycle; quotient reset to 0; quotient 0 on the error path.
- REQ-017 Without MOD_SHIFT_REDUCE_QUOT_EN, the quotient port and its register SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
- REQ-018 Package mod_shift_reduce_pkg SHALL hold the FSM state enum (IDLE/CALC/DONE) and error-code constants.
- REQ-019 The compare-and-subtract step SHALL be a combinational sub-module mod_sub_step (inputs r', modulus; outputs next r, quotient bit).

Verification
- REQ-020 num_in=5, len=8, modulus=7 -> result=6, err=0, done 41 cycles after start; with QUOT_EN, quotient=182.
- REQ-021 num_in=100, len=0, modulus=7 -> result=2, done 33 cycles after start.
- REQ-022 num_in=0xFFFFFFFF, len=32, modulus=0xFFFFFFFB -> result=20 after 65 cycles; modulus=0 or len=33 -> err=1, result=0, done 1 cycle after start.
- REQ-023 start pulsed during CALC with different operands -> ignored; first result unchanged; single done pulse.
- REQ-024 rstn low at CALC cycle 10 -> all outputs 0 immediately; no done after release; a subsequent start yields the correct result.
